tx_buffered_engine: RTL and testbench

TX_BUFFERED_ENGINE -- requirements
Module: tx_buffered_engine

---
 rtl/tx_buffered_engine_pkg.sv | 37 +++
 rtl/tx_fifo.sv | 57 +++++
 rtl/tx_buffered_engine.sv | 123 ++++++++++++
 tb/tb_tx_buffered_engine.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_buffered_engine_pkg.sv
// Shared types and constants for the buffered serial transmitter:
// FSM encodings, frame geometry, parity select and the frame builder.
package tx_buffered_engine_pkg;

  localparam int FRAME_BITS = 11;
  localparam int BAUD_W     = 19;
  localparam int DATA_W     = 8;
  localparam int BIT_CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } tx_state_e;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_sel_e;

  // Frame in transmit order, bit 0 first: start, nine payload bits, stop.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [DATA_W-1:0] d,
    input logic              eight,
    input logic              pen,
    input par_sel_e          par_sel
  );
    logic       parity;
    logic [8:0] payload;
    parity       = (eight ? ^d : ^d[6:0]) ^ (par_sel == PAR_ODD);
    payload[6:0] = d[6:0];
    payload[7]   = eight ? d[7] : (pen ? parity : 1'b1);
    payload[8]   = (eight && pen) ? parity : 1'b1;
    return {1'b1, payload, 1'b0};
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Holding FIFO for bytes awaiting transmission; full/empty come from an
// occupancy count so all DEPTH entries are usable.
module tx_fifo
  import tx_buffered_engine_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetNew,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];

  // NOTE: the storage array has no reset; validity is tracked by the count,
  // so resetting the data would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge resetNew) begin
    if (resetNew) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tx_buffered_engine.sv
// Buffered asynchronous-serial transmitter: a holding FIFO feeds an
// IDLE/LOAD/SHIFT engine that sends 11-bit frames, each bit K clocks long.
module tx_buffered_engine
  import tx_buffered_engine_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetNew,
  input  logic              write0,
  input  logic [7:0]        out_port,
  input  logic [18:0]       baud,
  input  logic              EIGHT,
  input  logic              PEN,
  input  logic              OHEL,
  output logic              TXRDY,
  output logic              TXIDLE,
  output logic              OVW,
  output logic              TX
);

  tx_state_e               state_q;
  logic                    tx_q;
  logic                    ovw_q;
  logic                    txidle_q;
  logic [FRAME_BITS-2:0]   shreg_q;
  logic [BAUD_W-1:0]       k_q;
  logic [BAUD_W-1:0]       baud_cnt_q;
  logic [BIT_CNT_W-1:0]    bit_cnt_q;

  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [DATA_W-1:0]       fifo_dout;
  logic [FRAME_BITS-1:0]   frame_w;
  logic                    bit_tick;
  logic                    shift_done;
  logic                    idle_next;

  // Only LOAD pops, and IDLE enters LOAD only when the FIFO holds data.
  assign fifo_pop  = (state_q == ST_LOAD);
  assign fifo_push = write0 && (!fifo_full || fifo_pop);
  assign frame_w   = build_frame(fifo_dout, EIGHT, PEN, par_sel_e'(OHEL));

  tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .resetNew (resetNew),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .din      (out_port),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave one unassigned and infer a latch.
    bit_tick   = 1'b0;
    shift_done = 1'b0;
    idle_next  = 1'b0;
    if (state_q == ST_SHIFT) begin
      bit_tick   = (baud_cnt_q == k_q - BAUD_W'(1));
      shift_done = bit_tick && (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1));
    end
    idle_next = ((state_q == ST_IDLE) && fifo_empty) || shift_done;
  end

  // NOTE: non-blocking assignments throughout, so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge resetNew) begin
    if (resetNew) begin
      state_q    <= ST_IDLE;
      tx_q       <= 1'b1;
      ovw_q      <= 1'b0;
      txidle_q   <= 1'b1;
      shreg_q    <= '1;
      k_q        <= BAUD_W'(1);
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      ovw_q    <= write0 && fifo_full && !fifo_pop;
      // Nothing pops outside LOAD, so a write is the only way to leave empty.
      txidle_q <= idle_next && fifo_empty && !write0;
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          tx_q       <= frame_w[0];
          shreg_q    <= frame_w[FRAME_BITS-1:1];
          k_q        <= (baud == '0) ? BAUD_W'(1) : baud;
          baud_cnt_q <= '0;
          bit_cnt_q  <= '0;
          state_q    <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (bit_tick) begin
            baud_cnt_q <= '0;
            if (shift_done) begin
              tx_q    <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              tx_q      <= shreg_q[0];
              shreg_q   <= {1'b1, shreg_q[FRAME_BITS-2:1]};
              bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + BAUD_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign TX     = tx_q;
  assign OVW    = ovw_q;
  assign TXIDLE = txidle_q;
  assign TXRDY  = ~fifo_full;

endmodule

// File: tb/tb_tx_buffered_engine.sv
// Scoreboard bench for tx_buffered_engine: stimulus queues hand-computed
// frames, a monitor decodes TX bit by bit and compares.
module tb_tx_buffered_engine;

  typedef struct {
    logic [10:0] bits;
    int          k;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetNew;
  logic        write0;
  logic [7:0]  out_port;
  logic [18:0] baud;
  logic        EIGHT;
  logic        PEN;
  logic        OHEL;
  logic        TXRDY;
  logic        TXIDLE;
  logic        OVW;
  logic        TX;

  exp_t sb_q[$];
  int   start_q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  tx_buffered_engine #(.DEPTH(4)) dut (
    .clk      (clk),
    .resetNew (resetNew),
    .write0   (write0),
    .out_port (out_port),
    .baud     (baud),
    .EIGHT    (EIGHT),
    .PEN      (PEN),
    .OHEL     (OHEL),
    .TXRDY    (TXRDY),
    .TXIDLE   (TXIDLE),
    .OVW      (OVW),
    .TX       (TX)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write one byte, queue its frame, return clocks from write edge to start bit.
  task automatic send(input logic [7:0] d, input logic [10:0] bits, input int k, output int lat);
    int w_edge;
    @(negedge clk);
    write0   = 1'b1;
    out_port = d;
    w_edge   = cyc + 1;
    sb_q.push_back('{bits: bits, k: k});
    @(negedge clk);
    write0 = 1'b0;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      if (TX === 1'b0) begin
        lat = cyc - w_edge;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_drain(input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && TXIDLE === 1'b1) begin
        done = 1'b1;
        break;
      end
    end
    check("drain", done, 1);
  endtask

  // Monitor: decode every frame on TX and compare against the scoreboard.
  initial begin : monitor
    exp_t        e;
    logic [10:0] got;
    bit          width_ok;
    bit          aborted;
    forever begin
      @(negedge clk);
      if (resetNew !== 1'b0 || TX !== 1'b0) continue;
      start_q.push_back(cyc);
      check("frame_expected", sb_q.size() != 0, 1);
      if (sb_q.size() == 0) begin
        for (int w = 0; w < 4000; w++) begin
          @(negedge clk);
          if (TX === 1'b1) break;
        end
        continue;
      end
      e        = sb_q.pop_front();
      got      = '0;
      width_ok = 1'b1;
      aborted  = 1'b0;
      for (int b = 0; b < 11; b++) begin
        for (int c = 0; c < e.k; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (resetNew !== 1'b0) begin
            aborted = 1'b1;
            break;
          end
          if (c == 0) got[b] = TX;
          else if (TX !== got[b]) width_ok = 1'b0;
        end
        if (aborted) break;
      end
      if (!aborted) begin
        check("frame_bits", got, e.bits);
        check("bit_width", width_ok, 1);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int lat;
    int c0;
    int lows;
    logic [7:0] d;

    resetNew = 1'b1;
    write0   = 1'b0;
    out_port = 8'h00;
    baud     = 19'd3;
    EIGHT    = 1'b0;
    PEN      = 1'b0;
    OHEL     = 1'b0;

    // Reset values while held.
    repeat (2) @(negedge clk);
    check("rst_tx", TX, 1);
    check("rst_txrdy", TXRDY, 1);
    check("rst_txidle", TXIDLE, 1);
    check("rst_ovw", OVW, 0);

    // Write on the first edge after release: 0x80, 7 bits, no parity, K=3.
    @(negedge clk);
    resetNew = 1'b0;
    write0   = 1'b1;
    out_port = 8'h80;
    sb_q.push_back('{bits: 11'b11100000000, k: 3});
    @(negedge clk);
    write0 = 1'b0;
    check("txidle_after_first_write", TXIDLE, 0);
    wait_drain(100);

    // 0x55, 8 bits, even parity, K=4.
    baud = 19'd4; EIGHT = 1'b1; PEN = 1'b1; OHEL = 1'b0;
    send(8'h55, 11'b10010101010, 4, lat);
    check("latency_55", lat, 2);
    wait_drain(100);

    // 0x83, 7 bits, odd parity, K=4; config changes mid-frame must not matter.
    baud = 19'd4; EIGHT = 1'b0; PEN = 1'b1; OHEL = 1'b1;
    send(8'h83, 11'b11100000110, 4, lat);
    check("latency_83", lat, 2);
    baud = 19'd1; EIGHT = 1'b1; PEN = 1'b0; OHEL = 1'b0;
    wait_drain(100);

    // K=0 behaves as K=1: 0x00, 8 bits, no parity.
    baud = 19'd0; EIGHT = 1'b1; PEN = 1'b0; OHEL = 1'b0;
    send(8'h00, 11'b11000000000, 1, lat);
    check("latency_k0", lat, 2);
    wait_drain(50);

    // Burst: five writes fill shifter + FIFO, sixth overflows, seventh lands on a LOAD pop.
    baud = 19'd2; EIGHT = 1'b1; PEN = 1'b0; OHEL = 1'b0;
    start_q.delete();
    @(negedge clk);
    c0 = cyc;
    for (int i = 0; i < 5; i++) begin
      d        = 8'(8'hA1 + i);
      write0   = 1'b1;
      out_port = d;
      sb_q.push_back('{bits: {2'b11, d, 1'b0}, k: 2});
      @(negedge clk);
    end
    check("txrdy_full", TXRDY, 0);
    check("ovw_fifth_write", OVW, 0);
    out_port = 8'hEE;
    @(negedge clk);
    check("ovw_pulse", OVW, 1);
    write0 = 1'b0;
    @(negedge clk);
    check("ovw_one_cycle", OVW, 0);
    check("txrdy_still_full", TXRDY, 0);
    while (cyc < c0 + 26) @(negedge clk);
    write0   = 1'b1;
    out_port = 8'hA6;
    sb_q.push_back('{bits: {2'b11, 8'hA6, 1'b0}, k: 2});
    @(negedge clk);
    write0 = 1'b0;
    check("ovw_push_at_pop", OVW, 0);
    check("txrdy_push_at_pop", TXRDY, 0);
    wait_drain(400);
    check("burst_frame_count", start_q.size(), 6);
    for (int i = 1; i < start_q.size(); i++) check("frame_gap", start_q[i] - start_q[i-1], 24);

    // Reset during bit 4 of 0x55 with 0x3C queued behind it.
    baud = 19'd4; EIGHT = 1'b1; PEN = 1'b1; OHEL = 1'b0;
    @(negedge clk);
    c0       = cyc;
    write0   = 1'b1;
    out_port = 8'h55;
    sb_q.push_back('{bits: 11'b10010101010, k: 4});
    @(negedge clk);
    out_port = 8'h3C;
    sb_q.push_back('{bits: 11'b10001111000, k: 4});
    @(negedge clk);
    write0 = 1'b0;
    while (cyc < c0 + 20) @(negedge clk);
    check("tx_bit4_before_reset", TX, 0);
    #1 resetNew = 1'b1;
    #1;
    check("reset_tx_high", TX, 1);
    check("reset_txrdy", TXRDY, 1);
    check("reset_txidle", TXIDLE, 1);
    check("reset_ovw", OVW, 0);
    repeat (3) @(negedge clk);
    resetNew = 1'b0;
    sb_q.delete();
    lows = 0;
    repeat (30) begin
      @(negedge clk);
      if (TX !== 1'b1) lows++;
    end
    check("no_residual_frame", lows, 0);
    check("txidle_after_reset", TXIDLE, 1);

    // Engine still works after the abort: 0x01, 8 bits, odd parity, K=1.
    baud = 19'd1; EIGHT = 1'b1; PEN = 1'b1; OHEL = 1'b1;
    send(8'h01, 11'b10000000010, 1, lat);
    check("latency_after_reset", lat, 2);
    wait_drain(50);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
